// File: rtl/resp_uart_tx.sv
// resp_uart_tx: sends the 16-bit DHT11 response word to the host as 8N1 UART bytes, low byte first.
// Define RESP_CHECKSUM_EN to append a third byte holding info[7:0] ^ info[15:8].
module resp_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bufferPronto,
  input  logic [15:0] info,
  output logic        bufferUsado,
  output logic        tx,
  output logic        ocupado
);
`ifdef RESP_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int SW = 8 * NB;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [SW-1:0] shiftBuf;
  logic [SW-1:0] frame;
  logic [1:0] byteIdx;
  logic [2:0] bitIdx;
  logic [15:0] baud;
  logic armed;
  logic accept;
  logic bitEnd;
`ifdef RESP_CHECKSUM_EN
  assign frame = {info[7:0] ^ info[15:8], info};
`else
  assign frame = info;
`endif
  assign accept = (state == IDLE) && bufferPronto && armed;
  assign bitEnd = baud == LAST;
  // shiftBuf shifts right once per data bit, so the next byte is already at the bottom when a byte ends
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      bufferUsado <= 1'b0;
      ocupado <= 1'b0;
      armed <= 1'b1;
      baud <= '0;
      bitIdx <= '0;
      byteIdx <= '0;
      shiftBuf <= '0;
    end else begin
      bufferUsado <= accept;
      armed <= accept ? 1'b0 : (!bufferPronto ? 1'b1 : armed);
      baud <= (state == IDLE || bitEnd) ? '0 : baud + 16'd1;
      case (state)
        IDLE: if (accept) begin
          shiftBuf <= frame;
          byteIdx <= '0;
          state <= START;
          tx <= 1'b0;
          ocupado <= 1'b1;
        end
        START: if (bitEnd) begin
          state <= DATA;
          bitIdx <= '0;
          tx <= shiftBuf[0];
          shiftBuf <= shiftBuf >> 1;
        end
        DATA: if (bitEnd) begin
          bitIdx <= bitIdx + 3'd1;
          state <= (bitIdx == 3'd7) ? STOP : DATA;
          tx <= (bitIdx == 3'd7) ? 1'b1 : shiftBuf[0];
          if (bitIdx != 3'd7) shiftBuf <= shiftBuf >> 1;
        end
        STOP: if (bitEnd) begin
          state <= (byteIdx == 2'(NB - 1)) ? IDLE : START;
          ocupado <= byteIdx != 2'(NB - 1);
          tx <= byteIdx == 2'(NB - 1);
          byteIdx <= byteIdx + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
